// File: rtl/uplus_rx_frame_buffer.sv
// rtl/uplus_rx_frame_buffer.sv - store-and-forward rx frame buffer that drops bad, runt, oversize and overflowed frames
module uplus_rx_frame_buffer #(
    parameter int P_ADDR_WIDTH = 11,
    parameter int P_MIN_LENGTH = 64,
    parameter int P_MAX_LENGTH = 9600
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic [31:0] o_good_frames,
    output logic [31:0] o_drop_frames,
    output logic        o_drop_pulse
);

    localparam int            DEPTH   = 2**P_ADDR_WIDTH;
    localparam int            PW      = P_ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);
    localparam logic [15:0]   MIN_LEN = 16'(P_MIN_LENGTH);
    localparam logic [15:0]   MAX_LEN = 16'(P_MAX_LENGTH);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_STORE = 2'd1,
        W_DROP  = 2'd2
    } wstate_t;

    // Number of valid bytes in a beat; holes in tkeep are simply not counted.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Frame storage: {tlast, tkeep, tdata} per entry, never reset.
    logic [72:0] ram_q [DEPTH];

    // Write side state
    wstate_t       state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [31:0]   good_cnt_q, good_cnt_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;
    logic          drop_pulse_q;

    // Read side state
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ram_vld_q;
    logic [72:0]   ram_rdata_q;
    logic          out_vld_q, out_vld_d;
    logic [72:0]   out_word_q, out_word_d;
    logic          skid_vld_q, skid_vld_d;
    logic [72:0]   skid_word_q, skid_word_d;

    // Write side decode
    logic [3:0]  beat_bytes;
    logic [15:0] cnt_base;
    logic [16:0] cnt_sum17;
    logic [15:0] cnt_sum;
    logic        buf_full;
    logic        frame_good;
    logic        oversize;
    logic        wr_en;
    logic        commit;
    logic        rewind;
    logic        drop_evt;

    // Read side decode
    logic        out_pop;
    logic [1:0]  held;
    logic        rd_en;

    // Running byte count including the current beat, saturating at 16'hFFFF.
    always_comb begin
        beat_bytes = popcount8(s_axis_tkeep);
        cnt_base   = (state_q == W_STORE) ? byte_cnt_q : 16'd0;
        cnt_sum17  = {1'b0, cnt_base} + {13'd0, beat_bytes};
        cnt_sum    = cnt_sum17[16] ? 16'hFFFF : cnt_sum17[15:0];
        buf_full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
        frame_good = !s_axis_tuser && (cnt_sum >= MIN_LEN) && (cnt_sum <= MAX_LEN);
        oversize   = cnt_sum > MAX_LEN;
    end

    // Write FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= W_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM next state: any tlast ends the frame, overflow/oversize divert to drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE, W_STORE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        state_d = W_IDLE;
                    end else if (buf_full || oversize) begin
                        state_d = W_DROP;
                    end else begin
                        state_d = W_STORE;
                    end
                end
            end
            W_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: RAM write, commit, rewind to last commit, drop event.
    always_comb begin
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            W_IDLE, W_STORE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        if (!buf_full && frame_good) begin
                            wr_en  = 1'b1;
                            commit = 1'b1;
                        end else begin
                            rewind   = 1'b1;
                            drop_evt = 1'b1;
                        end
                    end else if (buf_full || oversize) begin
                        rewind = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            W_DROP: begin
                rewind = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pointer and counter next state for the write side.
    always_comb begin
        if (rewind) begin
            wr_ptr_d = cm_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        cm_ptr_d   = commit ? (wr_ptr_q + ONE_P) : cm_ptr_q;
        byte_cnt_d = wr_en ? cnt_sum : byte_cnt_q;
        good_cnt_d = good_cnt_q + {31'd0, commit};
        drop_cnt_d = drop_cnt_q + {31'd0, drop_evt};
    end

    // Write side registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            good_cnt_q   <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            good_cnt_q   <= good_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_evt;
        end
    end

    // RAM write port; the beat goes in at wr_ptr even when it closes the frame.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_reset) begin
            ram_q[wr_ptr_q[P_ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Fetch from committed region only; at most two words live outside the RAM
    // (output + skid) counting the read in flight, so the skid never overflows.
    always_comb begin
        out_pop  = out_vld_q && m_axis_tready;
        held     = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q} - {1'b0, out_pop};
        rd_en    = (rd_ptr_q != cm_ptr_q) && (held < 2'd2);
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_en};
    end

    // RAM read port with registered data, one cycle latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ram_vld_q   <= 1'b0;
            ram_rdata_q <= '0;
        end else begin
            ram_vld_q <= rd_en;
            if (rd_en) begin
                ram_rdata_q <= ram_q[rd_ptr_q[P_ADDR_WIDTH-1:0]];
            end
        end
    end

    // Output register refills from skid first, then from RAM; a RAM word that
    // arrives while the output is stalled parks in the skid register.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_word_d  = out_word_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        if (!out_vld_q || out_pop) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_word_d = skid_word_q;
                skid_vld_d = ram_vld_q;
                if (ram_vld_q) begin
                    skid_word_d = ram_rdata_q;
                end
            end else if (ram_vld_q) begin
                out_vld_d  = 1'b1;
                out_word_d = ram_rdata_q;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (ram_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_word_d = ram_rdata_q;
        end
    end

    // Read side registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr_q    <= '0;
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_word_q[63:0];
    assign m_axis_tkeep  = out_word_q[71:64];
    assign m_axis_tlast  = out_word_q[72];
    assign o_good_frames = good_cnt_q;
    assign o_drop_frames = drop_cnt_q;
    assign o_drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_uplus_rx_frame_buffer.sv
// tb/tb_uplus_rx_frame_buffer.sv - directed self-checking bench for uplus_rx_frame_buffer
module tb_uplus_rx_frame_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        m_axis_tready = 1'b0;

    logic        m_tvalid, m_tlast, drop_pulse;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [31:0] good_frames, drop_frames;

    logic        sm_tvalid, sm_tlast, sm_pulse;
    logic [63:0] sm_tdata;
    logic [7:0]  sm_tkeep;
    logic [31:0] sm_good, sm_drop;

    uplus_rx_frame_buffer dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .o_good_frames(good_frames), .o_drop_frames(drop_frames), .o_drop_pulse(drop_pulse)
    );

    uplus_rx_frame_buffer #(.P_ADDR_WIDTH(4)) dut_small (
        .i_clk(i_clk), .i_reset(i_reset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(sm_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(sm_tdata),
        .m_axis_tkeep(sm_tkeep), .m_axis_tlast(sm_tlast),
        .o_good_frames(sm_good), .o_drop_frames(sm_drop), .o_drop_pulse(sm_pulse)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [72:0] outq[$];
    logic [72:0] exp_q[$];
    int          bubble_cnt = 0;
    int          pulse_cnt = 0;
    int          stall_err = 0;
    int          sm_beats = 0;
    int          sm_lasts = 0;
    int          first_vld_cyc = -1;
    int          last_tlast_cyc = 0;
    bit          bp_run = 0;

    bit          in_frame = 0;
    bit          prev_stall = 0;
    logic [72:0] prev_word = '0;

    // Observe outputs on the falling edge, away from the sampling edge.
    always @(negedge i_clk) begin
        logic [72:0] cur;
        cur = {m_tlast, m_tkeep, m_tdata};
        if (i_reset) begin
            in_frame   = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall && (!m_tvalid || cur !== prev_word)) stall_err++;
            if (m_tvalid && m_axis_tready) begin
                outq.push_back(cur);
                in_frame = !m_tlast;
            end else if (in_frame && m_axis_tready && !m_tvalid) begin
                bubble_cnt++;
            end
            prev_stall = m_tvalid && !m_axis_tready;
            prev_word  = cur;
            if (first_vld_cyc < 0 && m_tvalid) first_vld_cyc = cyc;
            if (drop_pulse) pulse_cnt++;
            if (sm_tvalid && m_axis_tready) begin
                sm_beats++;
                if (sm_tlast) sm_lasts++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int data_diff();
        int d = 0;
        if (outq.size() != exp_q.size()) d++;
        for (int i = 0; i < outq.size() && i < exp_q.size(); i++) begin
            if (outq[i] !== exp_q[i]) d++;
        end
        return d;
    endfunction

    function automatic logic [7:0] last_out_keep();
        if (outq.size() == 0) return 8'hxx;
        return outq[outq.size()-1][71:64];
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
        s_axis_tkeep = '0;
        s_axis_tdata = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        outq.delete();
        exp_q.delete();
        bubble_cnt = 0;
        pulse_cnt = 0;
        stall_err = 0;
        sm_beats = 0;
        sm_lasts = 0;
        first_vld_cyc = -1;
    endtask

    task automatic send_frame(input int nbytes, input bit tuser, input bit exp_good);
        int nbeats;
        nbeats = (nbytes + 7) / 8;
        for (int b = 0; b < nbeats; b++) begin
            logic [7:0]  keep;
            logic [63:0] d;
            bit          last;
            last = (b == nbeats - 1);
            keep = 8'hFF;
            if (last) keep = keep >> (8 - (nbytes - 8 * b));
            d = {$urandom(), $urandom()};
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = keep;
            s_axis_tlast  = last;
            s_axis_tuser  = last ? tuser : 1'b0;
            if (exp_good) exp_q.push_back({last, keep, d});
            @(posedge i_clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        last_tlast_cyc = cyc;
    endtask

    task automatic send_partial(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom(), $urandom()};
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
            @(posedge i_clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            @(posedge i_clk);
            #1;
            k++;
        end
        repeat (20) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast = 1'b1;
        s_axis_tkeep = 8'hFF;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
        n_cmp++; if (m_tdata !== 64'd0) begin n_bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        n_cmp++; if (m_tkeep !== 8'd0) begin n_bad++; $display("FAIL reset_tkeep: got %h want 0", m_tkeep); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast: got %0b want 0", m_tlast); end
        n_cmp++; if (good_frames !== 32'd0) begin n_bad++; $display("FAIL reset_good: got %0d want 0", good_frames); end
        n_cmp++; if (drop_frames !== 32'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_frames); end
        n_cmp++; if (drop_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %0b want 0", drop_pulse); end
        n_cmp++; if (sm_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_small_tvalid: got %0b want 0", sm_tvalid); end
        @(posedge i_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
    endtask

    task automatic test_good_frame();
        int lat;
        do_reset();
        m_axis_tready = 1'b1;
        send_frame(64, 1'b0, 1'b1);
        wait_out(8, 50);
        lat = first_vld_cyc - last_tlast_cyc;
        n_cmp++; if (outq.size() !== 8) begin n_bad++; $display("FAIL good_beats: got %0d want 8", outq.size()); end
        n_cmp++; if (data_diff() !== 0) begin n_bad++; $display("FAIL good_data: %0d differing beats want 0", data_diff()); end
        n_cmp++; if (last_out_keep() !== 8'hFF) begin n_bad++; $display("FAIL good_last_keep: got %h want ff", last_out_keep()); end
        n_cmp++; if (first_vld_cyc < 0 || lat > 3) begin n_bad++; $display("FAIL good_latency: got %0d cycles want <=3", lat); end
        n_cmp++; if (bubble_cnt !== 0) begin n_bad++; $display("FAIL good_bubbles: got %0d want 0", bubble_cnt); end
        n_cmp++; if (good_frames !== 32'd1) begin n_bad++; $display("FAIL good_count: got %0d want 1", good_frames); end
        n_cmp++; if (drop_frames !== 32'd0) begin n_bad++; $display("FAIL good_drops: got %0d want 0", drop_frames); end
    endtask

    task automatic test_error_frame();
        do_reset();
        m_axis_tready = 1'b1;
        send_frame(64, 1'b1, 1'b0);
        send_frame(65, 1'b0, 1'b1);
        wait_out(9, 60);
        n_cmp++; if (outq.size() !== 9) begin n_bad++; $display("FAIL err_beats: got %0d want 9", outq.size()); end
        n_cmp++; if (data_diff() !== 0) begin n_bad++; $display("FAIL err_data: %0d differing beats want 0", data_diff()); end
        n_cmp++; if (last_out_keep() !== 8'h01) begin n_bad++; $display("FAIL err_last_keep: got %h want 01", last_out_keep()); end
        n_cmp++; if (drop_frames !== 32'd1) begin n_bad++; $display("FAIL err_drops: got %0d want 1", drop_frames); end
        n_cmp++; if (good_frames !== 32'd1) begin n_bad++; $display("FAIL err_good: got %0d want 1", good_frames); end
        n_cmp++; if (pulse_cnt !== 1) begin n_bad++; $display("FAIL err_pulse: got %0d cycles want 1", pulse_cnt); end
    endtask

    task automatic test_length_limits();
        do_reset();
        m_axis_tready = 1'b1;
        send_frame(60, 1'b0, 1'b0);
        send_frame(9608, 1'b0, 1'b0);
        send_frame(9600, 1'b0, 1'b1);
        wait_out(1200, 3000);
        n_cmp++; if (outq.size() !== 1200) begin n_bad++; $display("FAIL len_beats: got %0d want 1200", outq.size()); end
        n_cmp++; if (data_diff() !== 0) begin n_bad++; $display("FAIL len_data: %0d differing beats want 0", data_diff()); end
        n_cmp++; if (drop_frames !== 32'd2) begin n_bad++; $display("FAIL len_drops: got %0d want 2", drop_frames); end
        n_cmp++; if (good_frames !== 32'd1) begin n_bad++; $display("FAIL len_good: got %0d want 1", good_frames); end
        n_cmp++; if (pulse_cnt !== 2) begin n_bad++; $display("FAIL len_pulse: got %0d want 2", pulse_cnt); end
        n_cmp++; if (bubble_cnt !== 0) begin n_bad++; $display("FAIL len_bubbles: got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        m_axis_tready = 1'b0;
        send_frame(64, 1'b0, 1'b0);
        send_frame(64, 1'b0, 1'b0);
        send_frame(64, 1'b0, 1'b0);
        repeat (10) @(posedge i_clk);
        #1;
        n_cmp++; if (sm_good !== 32'd2) begin n_bad++; $display("FAIL ovf_good: got %0d want 2", sm_good); end
        n_cmp++; if (sm_drop !== 32'd1) begin n_bad++; $display("FAIL ovf_drops: got %0d want 1", sm_drop); end
        n_cmp++; if (sm_beats !== 0) begin n_bad++; $display("FAIL ovf_stalled_beats: got %0d want 0", sm_beats); end
        m_axis_tready = 1'b1;
        repeat (40) @(posedge i_clk);
        #1;
        n_cmp++; if (sm_beats !== 16) begin n_bad++; $display("FAIL ovf_beats: got %0d want 16", sm_beats); end
        n_cmp++; if (sm_lasts !== 2) begin n_bad++; $display("FAIL ovf_lasts: got %0d want 2", sm_lasts); end
    endtask

    task automatic test_backpressure();
        do_reset();
        m_axis_tready = 1'b0;
        bp_run = 1'b1;
        fork
            begin
                while (bp_run) begin
                    @(posedge i_clk);
                    #1;
                    if (bp_run) m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int f = 0; f < 100; f++) begin
            send_frame(int'($urandom_range(64, 200)), 1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
        end
        wait_out(exp_q.size(), 20000);
        bp_run = 1'b0;
        repeat (2) @(posedge i_clk);
        #2;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        n_cmp++; if (outq.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_beats: got %0d want %0d", outq.size(), exp_q.size()); end
        n_cmp++; if (data_diff() !== 0) begin n_bad++; $display("FAIL bp_data: %0d differing beats want 0", data_diff()); end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        n_cmp++; if (good_frames !== 32'd100) begin n_bad++; $display("FAIL bp_good: got %0d want 100", good_frames); end
        n_cmp++; if (drop_frames !== 32'd0) begin n_bad++; $display("FAIL bp_drops: got %0d want 0", drop_frames); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        m_axis_tready = 1'b1;
        send_partial(4);
        do_reset();
        send_frame(64, 1'b0, 1'b1);
        wait_out(8, 50);
        n_cmp++; if (outq.size() !== 8) begin n_bad++; $display("FAIL rstmid_beats: got %0d want 8", outq.size()); end
        n_cmp++; if (data_diff() !== 0) begin n_bad++; $display("FAIL rstmid_data: %0d differing beats want 0", data_diff()); end
        n_cmp++; if (good_frames !== 32'd1) begin n_bad++; $display("FAIL rstmid_good: got %0d want 1", good_frames); end
        n_cmp++; if (drop_frames !== 32'd0) begin n_bad++; $display("FAIL rstmid_drops: got %0d want 0", drop_frames); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_error_frame();
        test_length_limits();
        test_overflow();
        test_backpressure();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uplus_rx_frame_buffer.md
UPLUS_RX_FRAME_BUFFER -- requirements
Module: uplus_rx_frame_buffer

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 11, buffer depth = 2**P_ADDR_WIDTH 64-bit words.
REQ-002 SHALL have parameter P_MIN_LENGTH, default 64, minimum accepted frame length in bytes.
REQ-003 SHALL have parameter P_MAX_LENGTH, default 9600, maximum accepted frame length in bytes.
REQ-004 SHALL use one clock and a synchronous, active-high reset, as follows.
- i_clk  in  1  MAC rx user clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  MAC rx beat valid; no backpressure exists.
- s_axis_tdata  in  64  MAC rx data.
- s_axis_tkeep  in  8  byte enables, bit n = byte n.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  frame error; meaningful only with tlast.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  64  output data.
- m_axis_tkeep  out  8  output byte enables.
- m_axis_tlast  out  1  output last beat.
- o_good_frames  out  32  committed frame count, wraps.
- o_drop_frames  out  32  dropped frame count, wraps.
- o_drop_pulse  out  1  one-cycle pulse per dropped frame.

Function
REQ-005 SHALL store frames in a 73-bit-wide RAM (data, tkeep, tlast), store-and-forward; only complete good frames are ever presented on m_axis.
REQ-006 SHALL keep write pointer wr_ptr, commit pointer cm_ptr and read pointer rd_ptr, each P_ADDR_WIDTH+1 bits, with the extra bit for full/empty.
REQ-007 Write FSM states SHALL be W_IDLE, W_STORE and W_DROP; on reset the state SHALL be W_IDLE.
REQ-008 W_IDLE: a valid beat without tlast SHALL be written, set byte count to popcount(tkeep) and go to W_STORE; a valid beat with tlast SHALL be evaluated as a one-beat frame.
REQ-009 W_STORE: each valid beat SHALL be written and popcount(tkeep) added to the 16-bit byte count; the count SHALL saturate at 16'hFFFF.
REQ-010 Overflow SHALL occur when a write is needed while wr_ptr - rd_ptr == depth; the beat is not written and the FSM goes to W_DROP.
REQ-011 Oversize SHALL occur when the byte count exceeds P_MAX_LENGTH before tlast; the FSM goes to W_DROP.
REQ-012 W_DROP SHALL write nothing, SHALL rewind wr_ptr to cm_ptr, and SHALL return to W_IDLE on the valid tlast beat, counting one drop.
REQ-013 On a valid tlast beat in W_IDLE/W_STORE, the frame SHALL be good iff tuser==0 and P_MIN_LENGTH <= total bytes <= P_MAX_LENGTH.
REQ-014 Good frame: cm_ptr SHALL be set to wr_ptr+1 on the next edge and o_good_frames incremented.
REQ-015 Bad frame: wr_ptr SHALL be set to cm_ptr on the next edge, o_drop_frames incremented, and o_drop_pulse high for exactly one cycle.
REQ-016 Read side SHALL present data while rd_ptr != cm_ptr, using a prefetch/skid stage so that m_axis_tvalid stays high with no bubbles from the first beat through tlast of a committed frame while tready is high.
REQ-017 m_axis_tvalid SHALL assert no later than 3 cycles after the edge that sampled a good tlast beat, when the buffer was otherwise empty.
REQ-018 m_axis_tdata/tkeep/tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-019 Output throughput SHALL be one beat per cycle with tready held high.
REQ-020 A commit and a read in the same cycle SHALL both take effect; pointer wrap at 2**(P_ADDR_WIDTH+1) SHALL be modular.
REQ-021 tkeep SHALL be counted by popcount; contiguity is not checked; tkeep=0 adds 0 bytes.

Reset
REQ-022 During reset, all pointers, counters, the FSM, the prefetch stage, m_axis_tvalid and o_drop_pulse SHALL be 0, and m_axis_tdata/tkeep/tlast SHALL be 0.
REQ-023 Reset mid-frame SHALL discard all stored and partial frames; the first valid beat after reset deasserts SHALL be treated as a frame start.
REQ-024 RAM contents SHALL NOT be reset.

Verification
REQ-025 Good frame: 8 full beats (64 B), tuser=0, tready=1 -> 8 identical beats out, last tkeep=FF, tvalid within 3 cycles, no bubbles, o_good_frames=1.
REQ-026 Error frame: 64 B with tuser=1 on tlast, then a 65 B good frame (last tkeep=01) -> only the 65 B frame appears; o_drop_frames=1, one o_drop_pulse.
REQ-027 Runt/oversize: 60 B frame, then 9608 B frame, then 9600 B frame -> only the 9600 B frame is output; drops=2.
REQ-028 Overflow: P_ADDR_WIDTH=4, tready=0, 3 frames of 64 B (8 beats each) -> frames 1-2 committed, frame 3 dropped; then tready=1 -> exactly 16 beats out.
REQ-029 Backpressure: random tready toggling over 100 random good frames -> byte-exact output in order, stable data while stalled, good count=100.
REQ-030 Reset after beat 4 of an 8-beat frame, then a new 64 B frame -> only the new frame is output, counters show good=1 and drops=0.
